// File: rtl/regfile_pkg.sv
// Shared register-file constants, writeback source tags and the onehot helper
// used to build the pending-write mask.
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;
  localparam int ZERO_REG   = 0;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } wb_src_e;

  // The zero register is never reported as pending.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    if (addr != REG_ADDR_W'(ZERO_REG)) oh[addr] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: two producer handshakes, the register-file write port and
// the stall-side status outputs.
interface regfile_wb_arbiter_if
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NUM_REGS-1:0] busy_mask;
  logic              idle;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, wr_en, wr_addr, wr_data, busy_mask, idle
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, wr_en, wr_addr, wr_data, busy_mask, idle
  );
endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// Small in-order FIFO of {addr,data} entries with explicit pointer wrap and a
// per-slot valid/address view so the owner can build a pending mask.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37,
  parameter int AW    = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  logic [W-1:0]        push_data_i,
  input  logic                pop_i,
  output logic                full_o,
  output logic                empty_o,
  output logic [W-1:0]        head_o,
  output logic [DEPTH-1:0]    ent_vld_o,
  output logic [DEPTH*AW-1:0] ent_addr_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic             push_en, pop_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  // A full FIFO refuses a push even when it pops in the same cycle.
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign ent_vld_o = vld_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_view
    assign ent_addr_o[i*AW +: AW] = mem_q[i][W-1 -: AW];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    vld_d    = vld_q;
    if (push_en) begin
      wr_ptr_d         = ptr_inc(wr_ptr_q);
      vld_d[wr_ptr_q]  = 1'b1;
    end
    if (pop_en) begin
      rd_ptr_d         = ptr_inc(rd_ptr_q);
      vld_d[rd_ptr_q]  = 1'b0;
    end
    if (push_en && !pop_en)      cnt_d = cnt_q + CW'(1);
    else if (pop_en && !push_en) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      vld_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin share of the register file write port between the ALU (A) and
// load (B) writeback paths, with a registered write port and pending mask.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input logic clk,
  input logic rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int W = ADDR_W + DATA_W;

  logic                a_full, a_empty, b_full, b_empty;
  logic [W-1:0]        a_head, b_head, sel_head;
  logic [DEPTH-1:0]    a_vld, b_vld;
  logic [DEPTH*ADDR_W-1:0] a_ent_addr, b_ent_addr;
  logic                gnt_a, gnt_b;
  logic [ADDR_W-1:0]   sel_addr;
  wb_src_e             rr_last_q, rr_last_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [NUM_REGS-1:0] busy_c;

  assign bus.a_ready = !rst && !a_full;
  assign bus.b_ready = !rst && !b_full;

  wb_fifo #(.DEPTH(DEPTH), .W(W), .AW(ADDR_W)) u_fifo_a (
    .clk(clk), .rst(rst),
    .push_i(bus.a_valid && bus.a_ready), .push_data_i({bus.a_addr, bus.a_data}),
    .pop_i(gnt_a), .full_o(a_full), .empty_o(a_empty), .head_o(a_head),
    .ent_vld_o(a_vld), .ent_addr_o(a_ent_addr)
  );

  wb_fifo #(.DEPTH(DEPTH), .W(W), .AW(ADDR_W)) u_fifo_b (
    .clk(clk), .rst(rst),
    .push_i(bus.b_valid && bus.b_ready), .push_data_i({bus.b_addr, bus.b_data}),
    .pop_i(gnt_b), .full_o(b_full), .empty_o(b_empty), .head_o(b_head),
    .ent_vld_o(b_vld), .ent_addr_o(b_ent_addr)
  );

  // On a tie the source that did not win last time gets the slot.
  assign gnt_a    = !rst && !a_empty && (b_empty || rr_last_q == SRC_B);
  assign gnt_b    = !rst && !b_empty && !gnt_a;
  assign sel_head = gnt_a ? a_head : b_head;
  assign sel_addr = sel_head[W-1 -: ADDR_W];

  always_comb begin
    rr_last_d = rr_last_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (gnt_a || gnt_b) begin
      rr_last_d = gnt_a ? SRC_A : SRC_B;
      // Writes to the zero register are dropped but still use up the slot.
      if (sel_addr != ADDR_W'(ZERO_REG)) begin
        wr_en_d   = 1'b1;
        wr_addr_d = sel_addr;
        wr_data_d = sel_head[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q <= SRC_B;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      rr_last_q <= rr_last_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    busy_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (a_vld[i]) busy_c |= reg_onehot(REG_ADDR_W'(a_ent_addr[i*ADDR_W +: ADDR_W]));
      if (b_vld[i]) busy_c |= reg_onehot(REG_ADDR_W'(b_ent_addr[i*ADDR_W +: ADDR_W]));
    end
    if (wr_en_q) busy_c |= reg_onehot(REG_ADDR_W'(wr_addr_q));
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.busy_mask = busy_c;
  assign bus.idle      = a_empty && b_empty && !wr_en_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scenario tasks plus a randomized run checked against a queue-based model of
// the two producers, the round-robin grant and the registered write port.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();
  regfile_wb_arbiter #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  ent_t        qa[$];
  ent_t        qb[$];
  bit          m_last_b;
  logic        m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [31:0] m_busy();
    logic [31:0] m;
    m = '0;
    foreach (qa[i]) if (qa[i].addr != 0) m[qa[i].addr] = 1'b1;
    foreach (qb[i]) if (qb[i].addr != 0) m[qb[i].addr] = 1'b1;
    if (m_en) m[m_addr] = 1'b1;
    return m;
  endfunction

  // Advance one clock, updating the reference model with the edge's events.
  task automatic tick();
    bit pa, pb, ga, gb;
    ent_t ea, eb, e;
    pa = bus.a_valid && !rst && (qa.size() < DEPTH);
    pb = bus.b_valid && !rst && (qb.size() < DEPTH);
    ea = {bus.a_addr, bus.a_data};
    eb = {bus.b_addr, bus.b_data};
    @(posedge clk);
    if (rst) begin
      qa.delete(); qb.delete();
      m_last_b = 1'b1; m_en = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      ga = (qa.size() > 0) && ((qb.size() == 0) || m_last_b);
      gb = (qb.size() > 0) && !ga;
      m_en = 1'b0;
      if (ga || gb) begin
        e = ga ? qa.pop_front() : qb.pop_front();
        m_last_b = gb;
        if (e.addr != 0) begin
          m_en = 1'b1; m_addr = e.addr; m_data = e.data;
        end
      end
      if (pa) qa.push_back(ea);
      if (pb) qb.push_back(eb);
    end
    #1;
  endtask

  task automatic drive_a(input bit v, input logic [4:0] a, input logic [31:0] d);
    bus.a_valid = v; bus.a_addr = a; bus.a_data = d;
  endtask

  task automatic drive_b(input bit v, input logic [4:0] a, input logic [31:0] d);
    bus.b_valid = v; bus.b_addr = a; bus.b_data = d;
  endtask

  task automatic do_reset();
    rst = 1'b1; drive_a(0, 0, 0); drive_b(0, 0, 0);
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; drive_a(1, 5'd3, 32'h1); drive_b(0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (bus.a_ready !== 1'b0) begin n_fail++; $display("FAIL reset_a_ready: got %b want 0", bus.a_ready); end
      n_cmp++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", bus.wr_en); end
      n_cmp++; if (bus.busy_mask !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", bus.busy_mask); end
      n_cmp++; if (bus.idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", bus.idle); end
    end
    n_cmp++; if (bus.wr_addr !== 5'd0 || bus.wr_data !== 32'd0) begin n_fail++; $display("FAIL reset_wr_port: got %h/%h want 0/0", bus.wr_addr, bus.wr_data); end
    rst = 1'b0; drive_a(0, 0, 0);
    #1;
    n_cmp++; if (bus.a_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_a_ready: got %b want 1", bus.a_ready); end
  endtask

  task automatic test_single_write();
    drive_a(1, 5'd5, 32'hDEADBEEF);
    tick();
    drive_a(0, 0, 0);
    n_cmp++; if (bus.busy_mask[5] !== 1'b1) begin n_fail++; $display("FAIL single_busy5: got %b want 1", bus.busy_mask[5]); end
    n_cmp++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL single_early_wr_en: got %b want 0", bus.wr_en); end
    tick();
    n_cmp++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd5 || bus.wr_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL single_issue: got en=%b addr=%0d data=%h want 1/5/deadbeef", bus.wr_en, bus.wr_addr, bus.wr_data); end
    tick();
    n_cmp++; if (bus.wr_en !== 1'b0 || bus.busy_mask !== 32'h0 || bus.idle !== 1'b1) begin
      n_fail++; $display("FAIL single_done: got en=%b busy=%h idle=%b want 0/0/1", bus.wr_en, bus.busy_mask, bus.idle); end
  endtask

  task automatic test_contention();
    logic [4:0] order [4];
    order[0] = 5'd1; order[1] = 5'd3; order[2] = 5'd2; order[3] = 5'd4;
    do_reset();
    drive_a(1, 5'd1, 32'h11); drive_b(1, 5'd3, 32'h33);
    tick();
    drive_a(1, 5'd2, 32'h22); drive_b(1, 5'd4, 32'h44);
    tick();
    drive_a(0, 0, 0); drive_b(0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      n_cmp++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== order[k] || bus.wr_data !== 32'h11 * order[k]) begin
        n_fail++; $display("FAIL contention_slot%0d: got en=%b addr=%0d data=%h want 1/%0d/%h",
                           k, bus.wr_en, bus.wr_addr, bus.wr_data, order[k], 32'h11 * order[k]); end
    end
    tick();
    n_cmp++; if (bus.idle !== 1'b1) begin n_fail++; $display("FAIL contention_idle: got %b want 1", bus.idle); end
  endtask

  task automatic test_back_to_back();
    ent_t got_a[$];
    int   a_sent = 0;
    bit   saw_stall = 0;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      if (k < 24) drive_b(1, 5'(16 + (k % 8)), 32'hB000_0000 | k);
      else        drive_b(0, 0, 0);
      if (a_sent < 6) drive_a(1, 5'(8 + a_sent), 32'hA000_0000 | a_sent);
      else            drive_a(0, 0, 0);
      #1;
      n_cmp++; if (bus.a_ready !== (qa.size() < DEPTH)) begin
        n_fail++; $display("FAIL bp_a_ready cycle %0d: got %b want %b", k, bus.a_ready, qa.size() < DEPTH); end
      if (bus.a_valid && bus.a_ready !== 1'b1) saw_stall = 1;
      if (bus.a_valid && qa.size() < DEPTH) a_sent++;
      tick();
      if (bus.wr_en === 1'b1 && bus.wr_data[31:28] == 4'hA) got_a.push_back({bus.wr_addr, bus.wr_data});
    end
    n_cmp++; if (saw_stall !== 1'b1) begin n_fail++; $display("FAIL bp_stall_seen: got %b want 1", saw_stall); end
    n_cmp++; if (got_a.size() != a_sent || a_sent != 6) begin
      n_fail++; $display("FAIL bp_count: got %0d issued / %0d sent want 6/6", got_a.size(), a_sent); end
    foreach (got_a[i]) begin
      n_cmp++; if (got_a[i].addr !== 5'(8 + i) || got_a[i].data !== (32'hA000_0000 | i)) begin
        n_fail++; $display("FAIL bp_order%0d: got %0d/%h want %0d/%h", i, got_a[i].addr, got_a[i].data, 8 + i, 32'hA000_0000 | i); end
    end
  endtask

  task automatic test_zero_reg();
    do_reset();
    drive_a(1, 5'd0, 32'd7);
    tick();
    drive_a(0, 0, 0);
    n_cmp++; if (bus.busy_mask !== 32'h0) begin n_fail++; $display("FAIL zero_busy_queued: got %h want 0", bus.busy_mask); end
    drive_b(1, 5'd9, 32'h99);
    tick();
    drive_b(0, 0, 0);
    n_cmp++; if (bus.wr_en !== 1'b0 || bus.wr_addr !== 5'd0) begin
      n_fail++; $display("FAIL zero_discard: got en=%b addr=%0d want 0/0", bus.wr_en, bus.wr_addr); end
    n_cmp++; if (bus.busy_mask !== 32'h200) begin n_fail++; $display("FAIL zero_busy_b: got %h want 00000200", bus.busy_mask); end
    tick();
    n_cmp++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd9 || bus.wr_data !== 32'h99) begin
      n_fail++; $display("FAIL zero_next_slot: got en=%b addr=%0d data=%h want 1/9/99", bus.wr_en, bus.wr_addr, bus.wr_data); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive_a(1, 5'(1 + k), 32'hA5A5_0000 | k);
      drive_b(1, 5'(10 + k), 32'h5A5A_0000 | k);
      tick();
    end
    n_cmp++; if (bus.wr_en !== 1'b1 || bus.busy_mask !== m_busy()) begin
      n_fail++; $display("FAIL mid_loaded: got en=%b busy=%h want 1/%h", bus.wr_en, bus.busy_mask, m_busy()); end
    rst = 1'b1; drive_a(0, 0, 0); drive_b(0, 0, 0);
    tick();
    rst = 1'b0;
    n_cmp++; if (bus.wr_en !== 1'b0 || bus.busy_mask !== 32'h0 || bus.idle !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset: got en=%b busy=%h idle=%b want 0/0/1", bus.wr_en, bus.busy_mask, bus.idle); end
    for (int k = 0; k < 6; k++) begin
      tick();
      n_cmp++; if (bus.wr_en !== 1'b0 || bus.idle !== 1'b1) begin
        n_fail++; $display("FAIL mid_stale%0d: got en=%b idle=%b want 0/1", k, bus.wr_en, bus.idle); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 39) == 0);
      drive_a($urandom_range(0, 1), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
      drive_b($urandom_range(0, 1), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
      tick();
      n_cmp++; if (bus.wr_en !== m_en || bus.wr_addr !== m_addr || bus.wr_data !== m_data) begin
        n_fail++; $display("FAIL rand_wr cycle %0d: got %b/%0d/%h want %b/%0d/%h", k, bus.wr_en, bus.wr_addr, bus.wr_data, m_en, m_addr, m_data); end
      n_cmp++; if (bus.busy_mask !== m_busy()) begin
        n_fail++; $display("FAIL rand_busy cycle %0d: got %h want %h", k, bus.busy_mask, m_busy()); end
      n_cmp++; if (bus.idle !== (qa.size() == 0 && qb.size() == 0 && !m_en)) begin
        n_fail++; $display("FAIL rand_idle cycle %0d: got %b", k, bus.idle); end
      n_cmp++; if (bus.a_ready !== (!rst && qa.size() < DEPTH) || bus.b_ready !== (!rst && qb.size() < DEPTH)) begin
        n_fail++; $display("FAIL rand_ready cycle %0d: got %b%b want %b%b", k, bus.a_ready, bus.b_ready,
                           !rst && qa.size() < DEPTH, !rst && qb.size() < DEPTH); end
    end
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    m_last_b = 1'b1; m_en = 1'b0; m_addr = '0; m_data = '0;
    rst = 1'b1;
    drive_a(0, 0, 0); drive_b(0, 0, 0);
    test_reset();
    test_single_write();
    test_contention();
    test_back_to_back();
    test_zero_reg();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
